// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit 7-segment driver: shadow/display double buffer, one-hot digit scan.
// Latency: outputs lag the scan index by 1 cycle; a load appears at the next frame boundary + 1 cycle.
// Backpressure: none; load is accepted every cycle, enable=0 freezes the scan and blanks the pins.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int DIV            = 1000,
    parameter bit HEX_EN         = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                load,
    input  logic [4*DIGITS-1:0] digits_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shadow_dig;
    logic [DIGITS-1:0]   shadow_dp;
    logic                pending;
    logic [4*DIGITS-1:0] disp_dig;
    logic [DIGITS-1:0]   disp_dp;

    logic [6:0]          seg_q;
    logic                dp_q;
    logic [DIGITS-1:0]   an_q;
    logic                fd_q;

    logic                tick;
    logic                frame_end;
    logic [DIGITS-1:0]   zero_from;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_sup;
    logic [DIGITS-1:0]   an_nxt;
    logic [6:0]          seg_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'h0:    glyph = 7'b1111110;
            4'h1:    glyph = 7'b0110000;
            4'h2:    glyph = 7'b1101101;
            4'h3:    glyph = 7'b1111001;
            4'h4:    glyph = 7'b0110011;
            4'h5:    glyph = 7'b1011011;
            4'h6:    glyph = 7'b1011111;
            4'h7:    glyph = 7'b1110000;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1111011;
            4'hA:    glyph = HEX_EN ? 7'b1110111 : 7'b0000000;
            4'hB:    glyph = HEX_EN ? 7'b0011111 : 7'b0000000;
            4'hC:    glyph = HEX_EN ? 7'b1001110 : 7'b0000000;
            4'hD:    glyph = HEX_EN ? 7'b0111101 : 7'b0000000;
            4'hE:    glyph = HEX_EN ? 7'b1001111 : 7'b0000000;
            default: glyph = HEX_EN ? 7'b1000111 : 7'b0000000;
        endcase
    endfunction

    // zero_from[i]: nibble i and every more significant nibble are zero
    always_comb begin : lz_scan
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run          = run & (disp_dig[4*i +: 4] == 4'h0);
            zero_from[i] = run;
        end
    end

    always_comb begin
        tick      = (presc == PRE_LAST);
        frame_end = tick && (idx == IDX_LAST);
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_sup   = 1'b0;
        an_nxt    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = disp_dig[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_sup   = zero_from[i] && (i != 0);
                an_nxt[i] = 1'b1;
            end
        end
        seg_nxt = (blank_lz && cur_sup) ? 7'b0000000 : glyph(cur_nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            shadow_dig <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            disp_dig   <= '0;
            disp_dp    <= '0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            an_q       <= '0;
            fd_q       <= 1'b0;
        end else begin
            if (enable) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick)
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                if (frame_end && pending) begin
                    disp_dig <= shadow_dig;
                    disp_dp  <= shadow_dp;
                    pending  <= 1'b0;
                end
                seg_q <= seg_nxt;
                dp_q  <= cur_dp;
                an_q  <= an_nxt;
                fd_q  <= frame_end;
            end else begin
                seg_q <= '0;
                dp_q  <= 1'b0;
                an_q  <= '0;
                fd_q  <= 1'b0;
            end
            // A load coinciding with a boundary lands in shadow after the old shadow was copied out
            if (load) begin
                shadow_dig <= digits_in;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end
        end
    end

    assign seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp         = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
    assign an         = SEG_ACTIVE_LOW ? ~an_q : an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (decimal/active-high and hex/active-low) share stimulus.
module tb_seg7_scan_driver;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SA = 7'b1110111, SB = 7'b0011111;
    localparam logic [6:0] SC = 7'b1001110, SF = 7'b1000111, SX = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst, enable, load, blank_lz;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1;
    logic [3:0]  an0, an1;

    int total = 0;
    int pass  = 0;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic        blz;
        logic [27:0] g0;
        logic [27:0] g1;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .DIV(2), .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0));

    seg7_scan_driver #(.DIGITS(4), .DIV(2), .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // s0/s1 are logical glyphs for each instance; dut1 pins are inverted except frame_done
    task automatic chk(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                       input logic d, input logic [3:0] a, input logic f);
        logic [12:0] e0, e1, a0, a1;
        e0 = {s0, d, a, f};
        e1 = {~s1, ~d, ~a, f};
        a0 = {seg0, dp0, an0, fd0};
        a1 = {seg1, dp1, an1, fd1};
        total++;
        if (a0 === e0) pass++;
        else $display("FAIL %s dut0 {seg,dp,an,fd} actual=%b required=%b", nm, a0, e0);
        total++;
        if (a1 === e1) pass++;
        else $display("FAIL %s dut1 {seg,dp,an,fd} actual=%b required=%b", nm, a1, e1);
    endtask

    task automatic wait_fd(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (fd0 !== 1'b1 && n < 20);
        total++;
        if (fd0 === 1'b1) pass++;
        else $display("FAIL %s frame_done timeout actual=%b required=1", nm, fd0);
    endtask

    // Eight cycles following a boundary: each digit held 2 cycles, frame_done on the last
    task automatic check_frame(input string nm, input logic [27:0] g0, input logic [27:0] g1,
                               input logic [3:0] dpv);
        int i;
        for (int k = 0; k < 8; k++) begin
            step();
            i = k / 2;
            chk(nm, g0[7*i +: 7], g1[7*i +: 7], dpv[i], 4'(1 << i), (k == 7));
        end
    endtask

    initial begin
        vt[0] = '{16'h1234, 4'b0100, 1'b0, {S1, S2, S3, S4}, {S1, S2, S3, S4}};
        vt[1] = '{16'h0007, 4'b0000, 1'b1, {SX, SX, SX, S7}, {SX, SX, SX, S7}};
        vt[2] = '{16'h0007, 4'b0000, 1'b0, {S0, S0, S0, S7}, {S0, S0, S0, S7}};
        vt[3] = '{16'hABCF, 4'b1001, 1'b0, {SX, SX, SX, SX}, {SA, SB, SC, SF}};
        vt[4] = '{16'h0500, 4'b0010, 1'b1, {SX, S5, S0, S0}, {SX, S5, S0, S0}};
        vt[5] = '{16'h0000, 4'b1110, 1'b1, {SX, SX, SX, S0}, {SX, SX, SX, S0}};
        vt[6] = '{16'h9860, 4'b0001, 1'b0, {S9, S8, S6, S0}, {S9, S8, S6, S0}};
        vt[7] = '{16'h00A0, 4'b0000, 1'b1, {SX, SX, SX, S0}, {SX, SX, SA, S0}};

        rst = 1'b1; enable = 1'b1; load = 1'b0; blank_lz = 1'b0;
        digits_in = 16'h0; dp_in = 4'h0;
        step();
        step();
        chk("reset", SX, SX, 1'b0, 4'b0000, 1'b0);
        rst = 1'b0;
        step();
        chk("first_out", S0, S0, 1'b0, 4'b0001, 1'b0);

        for (int v = 0; v < 8; v++) begin
            digits_in = vt[v].val;
            dp_in     = vt[v].dpv;
            blank_lz  = vt[v].blz;
            load      = 1'b1;
            step();
            load = 1'b0;
            if (v > 0)
                chk($sformatf("old%0d", v), vt[v-1].g0[6:0], vt[v-1].g1[6:0],
                    vt[v-1].dpv[0], 4'b0001, 1'b0);
            wait_fd($sformatf("wait%0d", v));
            check_frame($sformatf("vec%0d", v), vt[v].g0, vt[v].g1, vt[v].dpv);
        end

        // load on the boundary edge while an earlier load is still pending
        digits_in = 16'h1111; dp_in = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 6; k++) step();
        digits_in = 16'h2222; load = 1'b1;
        step();
        load = 1'b0;
        chk("ld_at_fb", vt[7].g0[27:21], vt[7].g1[27:21], vt[7].dpv[3], 4'b1000, 1'b1);
        check_frame("prior_val", {S1, S1, S1, S1}, {S1, S1, S1, S1}, 4'h0);
        check_frame("new_val", {S2, S2, S2, S2}, {S2, S2, S2, S2}, 4'h0);

        // freeze mid-slot, then resume with the leftover slot cycle
        step();
        chk("pre_dis", S2, S2, 1'b0, 4'b0001, 1'b0);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("disabled", SX, SX, 1'b0, 4'b0000, 1'b0);
        end
        enable = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("resume", S2, S2, 1'b0, 4'(1 << ((k + 1) / 2)), (k == 6));
        end

        // reset mid-frame with a load pending and another load on the reset edge
        blank_lz = 1'b0;
        step();
        step();
        digits_in = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        step();
        rst = 1'b1; digits_in = 16'h6666; load = 1'b1;
        step();
        chk("rst_mid", SX, SX, 1'b0, 4'b0000, 1'b0);
        rst = 1'b0; load = 1'b0;
        step();
        chk("rst_d0", S0, S0, 1'b0, 4'b0001, 1'b0);
        wait_fd("wait_rst");
        check_frame("rst_clr", {S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'h0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed multi-digit seven-segment display driver. It is the parametrised successor to the team's single-digit BCD-to-7-segment decoder. It holds a DIGITS-wide packed BCD/hex value, time-multiplexes it onto one shared segment bus with one-hot digit enables, and updates the displayed value only at frame boundaries so the display never tears. Optional features are leading-zero suppression, per-digit decimal points, hex glyphs and active-low pin polarity. It sits between the datapath that produces counts and the board display pins.

## Interface
- DIGITS, 4: number of digits scanned; minimum 1.
- DIV, 1000: clock cycles per digit slot (refresh prescaler); minimum 1.
- HEX_EN, 0: 1 shows codes 10–15 as A b C d E F; 0 blanks them.
- SEG_ACTIVE_LOW, 0: 1 inverts the seg, dp and an pins.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 runs scanning; 0 freezes the scan and blanks the outputs.
- load  in  1  single-cycle strobe that captures digits_in and dp_in.
- digits_in  in  4*DIGITS  packed nibbles; [3:0] is digit 0, the least significant digit.
- dp_in  in  DIGITS  decimal point per digit; bit i belongs to digit i.
- blank_lz  in  1  1 enables leading-zero suppression.
- seg  out  7  segments {a,b,c,d,e,f,g}, a = MSB; registered.
- dp  out  1  decimal point of the active digit; registered.
- an  out  DIGITS  one-hot enable for the active digit; registered.
- frame_done  out  1  one-cycle pulse at each frame boundary; registered.

## Operation
- **Registers**
  - prescaler, 0..DIV-1.
  - index, 0..DIGITS-1.
  - shadow: digits and dp values.
  - pending flag.
  - display: digits and dp values.
  - output registers.
- **Load**
  - On load=1, shadow takes digits_in and dp_in, and pending is set.
  - load is accepted in every cycle, whatever the enable level.
- **Scanning (enable=1)**
  - prescaler increments each cycle.
  - tick = (prescaler==DIV-1). On tick, prescaler returns to 0 and index advances modulo DIGITS.
- **Frame boundary**
  - A frame boundary is a tick with index==DIGITS-1; index wraps to 0.
  - At a frame boundary:
    - If pending=1, display takes shadow and pending clears.
    - frame_done is 1 in the following cycle.
- **Load at a frame boundary**
  - When load and a frame boundary occur in the same cycle, display takes the shadow contents from before that edge (only if pending was already 1).
  - The new data stays in shadow with pending=1 and appears at the next frame boundary.
- **Glyphs (logical, active-high)**
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011.
  - 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011.
  - With HEX_EN=1: A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
  - With HEX_EN=0, codes 10–15 give 0000000.
- **Leading-zero suppression**
  - When blank_lz=1, digit i>0 shows seg=0000000 if its nibble and every higher nibble are 0.
  - Digit 0 is never suppressed.
  - dp of a suppressed digit is still driven from display.
- **Output registers**
  - seg takes the glyph of display digit[index].
  - dp takes display dp[index].
  - an is one-hot at bit index.
- **Disable**
  - While enable=0, prescaler, index and display hold, and frame_done=0.
  - seg, dp and an register to all-off (logical 0).
- **Pin polarity**
  - With SEG_ACTIVE_LOW=1, seg, dp and an are inverted at the pins.
  - frame_done is never inverted.

## Timing
- **Reset**
  - Clears prescaler, index, shadow, display and pending.
  - Output registers take logical seg=0000000, dp=0, an=0 and frame_done=0; all pins read 1 when SEG_ACTIVE_LOW=1.
  - A reset asserted mid-frame or mid-load takes effect at the next edge and discards any pending load.
- **Output latency**
  - Outputs lag index by 1 cycle.
  - In the first cycle after rst deasserts with enable=1, the outputs still show the reset values.
  - From the second cycle, the outputs show digit 0 with display=0: seg=1111110 and an=0…001.
- **Slot and frame lengths**
  - Each digit slot lasts DIV cycles.
  - A frame lasts DIGITS*DIV cycles.
  - With DIV=1, index advances every cycle.
- **Load to display**
  - Latency is bounded by one frame plus 1 cycle after the boundary.
  - Several loads within one frame: the last one wins.
- **Re-enable**
  - After enable returns to 1, scanning resumes from the held prescaler and index.
  - The outputs become valid 1 cycle later.

## Test plan
- DIGITS=4, DIV=2, reset, load digits_in=16'h1234 with dp_in=4'b0100 -> after the first frame boundary, an cycles 0001→0010→0100→1000 with each value held 2 cycles. seg reads 4:0110011, 3:1111001, 2:1101101 with dp=1, 1:0110000. frame_done pulses every 8 cycles.
- Load 16'h0007 mid-frame -> the old value is shown until the boundary. With blank_lz=1, digits 1–3 show seg=0 and digit 0 shows 1110000. With blank_lz=0, digits 1–3 show 1111110.
- HEX_EN=0 then HEX_EN=1, load 16'hABCF -> blank for all four digits, then F,C,b,A patterns on digits 0..3. Digit 0 shows 1000111.
- load asserted in the same cycle as a frame boundary, with a prior load pending -> the prior value is displayed in this frame and the new value at the next boundary.
- enable=0 for 5 cycles mid-slot -> an/seg/dp=0 and frame_done stays 0. On re-enable, the same index resumes with the remaining slot cycles preserved.
- rst pulsed mid-frame with SEG_ACTIVE_LOW=1 -> the next cycle shows all pins 1, index=0 and pending cleared.
